wg_done_tracker: RTL and testbench
==================================

# wg_done_tracker

Consumer end of the wavefront-done stream. Receives per-wavefront completion handshakes (valid/ready plus workgroup ID) as emitted by the wavefront-done buffer toward the host. Keeps a per-workgroup count of outstanding wavefronts and emits exactly one workgroup-done handshake when the last wavefront of a workgroup retires. Sits host-side, between the wavefront-done buffer and the CTA scheduler's workgroup release logic.

## Interface
- WG_ID_WIDTH, 15, workgroup ID width
- WG_NUM_MAX, 32, tracking-table entries (max concurrently live workgroups)
- WF_CNT_WIDTH, 6, width of wavefront count per workgroup (legal 1..2^WF_CNT_WIDTH-1)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- alloc_valid_i  in  1  new workgroup dispatched
- alloc_ready_o  out  1  free table entry available
- alloc_wg_id_i  in  WG_ID_WIDTH  dispatched workgroup ID
- alloc_wf_count_i  in  WF_CNT_WIDTH  wavefronts in that workgroup
- wf_done_valid_i  in  1  wavefront-done event
- wf_done_ready_o  out  1  event accepted
- wf_done_wg_id_i  in  WG_ID_WIDTH  workgroup of finished wavefront
- wg_done_valid_o  out  1  workgroup complete
- wg_done_ready_i  in  1  consumer accepts completion
- wg_done_wg_id_o  out  WG_ID_WIDTH  completed workgroup ID
- err_o  out  1  one-cycle pulse: unknown-ID wf_done, duplicate alloc, or zero-count alloc
- live_cnt_o  out  $clog2(WG_NUM_MAX)+1  number of valid table entries

## Operation
- Table: WG_NUM_MAX entries {vld, wg_id, remaining}; all vld=0 at reset.
- Alloc fires on alloc_valid_i & alloc_ready_o. alloc_ready_o = any entry vld=0 (registered state only).
  - Writes lowest-index free entry: vld=1, wg_id, remaining=alloc_wf_count_i.
  - alloc_wf_count_i==0, or wg_id already valid in table: no write, err_o pulse next cycle.
- wf_done fires on wf_done_valid_i & wf_done_ready_o. wf_done_ready_o = !wg_done_valid_o | wg_done_ready_i.
  - Fully associative lookup on wg_id over vld entries (state at start of cycle).
  - Hit, remaining>1: remaining-1.
  - Hit, remaining==1: entry vld=0; output register loads wg_id.
  - Miss: event dropped, err_o pulse next cycle.
- Output register: wg_done_valid_o set on final-wavefront hit; cleared on wg_done_ready_i with no new load; back-to-back load allowed when drained in the same cycle.
- Simultaneous alloc and wf_done:
  - Independent. An entry freed this cycle is not allocatable until next cycle.
  - A wf_done for a wg_id allocated in the same cycle misses (err).
  - Alloc duplicate check sees start-of-cycle state plus no same-cycle writes.
- live_cnt_o: registered; +1 per alloc, -1 per free; both in one cycle leave it unchanged.

## Timing
- Reset values: wg_done_valid_o=0, wg_done_wg_id_o=0, err_o=0, live_cnt_o=0; consequently wf_done_ready_o=1, alloc_ready_o=1.
- Alloc visible to lookup: 1 cycle after handshake.
- Final wf_done handshake in cycle N: wg_done_valid_o=1 in cycle N+1. Throughput 1 completion/cycle while wg_done_ready_i held high.
- wg_done_valid_o/wg_done_wg_id_o stable while valid & !ready.
- err_o high exactly one cycle per error event; at most one alloc error and one wf_done error per cycle, OR-ed.
- Reset mid-operation: table cleared; pending output dropped immediately (async).

## Test plan
- Alloc wg 5 count 3; three wf_done(5) with ready high -> wg_done_valid_o one cycle after the third, wg_done_wg_id_o=5; live_cnt_o 1 -> 0.
- Alloc wg 1 (count 1) and wg 2 (count 1); wg_done_ready_i=0; wf_done(1) then wf_done(2) -> wf_done_ready_o=0 for the second until ready; wg_done_wg_id_o 1 then 2 in order, no loss.
- Fill 32 entries -> alloc_ready_o=0. Retire one -> alloc_ready_o=1 the next cycle; the new alloc takes the freed index.
- wf_done(99) with no entry -> err_o pulses 1 cycle; table unchanged. Alloc count 0 -> err_o; alloc duplicate live ID -> err_o, live_cnt_o unchanged.
- Same cycle: alloc wg 7 plus final wf_done of wg 3 -> wg 3 completes, wg 7 live, live_cnt_o unchanged.
- Assert rst_n low with wg_done_valid_o=1 -> all outputs to reset values asynchronously; after release wf_done(prior ID) -> err_o.

Source files
------------

// File: rtl/wg_done_tracker.sv
// Host-side workgroup completion tracker: counts outstanding wavefronts per live
// workgroup and emits one workgroup-done handshake when the last one retires.
module wg_done_tracker #(
    parameter int WG_ID_WIDTH  = 15,
    parameter int WG_NUM_MAX   = 32,
    parameter int WF_CNT_WIDTH = 6
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            alloc_valid_i,
    output logic                            alloc_ready_o,
    input  logic [WG_ID_WIDTH-1:0]          alloc_wg_id_i,
    input  logic [WF_CNT_WIDTH-1:0]         alloc_wf_count_i,
    input  logic                            wf_done_valid_i,
    output logic                            wf_done_ready_o,
    input  logic [WG_ID_WIDTH-1:0]          wf_done_wg_id_i,
    output logic                            wg_done_valid_o,
    input  logic                            wg_done_ready_i,
    output logic [WG_ID_WIDTH-1:0]          wg_done_wg_id_o,
    output logic                            err_o,
    output logic [$clog2(WG_NUM_MAX):0]     live_cnt_o
);

    localparam int IDX_W  = (WG_NUM_MAX > 1) ? $clog2(WG_NUM_MAX) : 1;
    localparam int LIVE_W = $clog2(WG_NUM_MAX) + 1;

    logic [WG_NUM_MAX-1:0]   vld_q, vld_d;
    logic [WG_ID_WIDTH-1:0]  id_q  [WG_NUM_MAX];
    logic [WG_ID_WIDTH-1:0]  id_d  [WG_NUM_MAX];
    logic [WF_CNT_WIDTH-1:0] rem_q [WG_NUM_MAX];
    logic [WF_CNT_WIDTH-1:0] rem_d [WG_NUM_MAX];

    logic                    out_vld_q, out_vld_d;
    logic [WG_ID_WIDTH-1:0]  out_id_q, out_id_d;
    logic                    err_q, err_d;
    logic [LIVE_W-1:0]       live_q, live_d;

    logic                    free_found;
    logic [IDX_W-1:0]        free_idx;
    logic                    dup_hit;
    logic                    wf_hit;
    logic [IDX_W-1:0]        wf_idx;

    logic                    alloc_fire, alloc_err, alloc_ok;
    logic                    wf_fire, wf_miss, wf_last;

    // All lookups use start-of-cycle table state, so same-cycle alloc and retire
    // never see each other.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        dup_hit    = 1'b0;
        wf_hit     = 1'b0;
        wf_idx     = '0;
        for (int i = WG_NUM_MAX - 1; i >= 0; i--) begin
            if (!vld_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < WG_NUM_MAX; i++) begin
            if (vld_q[i] && id_q[i] == alloc_wg_id_i) begin
                dup_hit = 1'b1;
            end
            if (vld_q[i] && id_q[i] == wf_done_wg_id_i) begin
                wf_hit = 1'b1;
                wf_idx = IDX_W'(i);
            end
        end
    end

    assign alloc_ready_o   = free_found;
    assign wf_done_ready_o = ~out_vld_q | wg_done_ready_i;

    assign alloc_fire = alloc_valid_i & alloc_ready_o;
    assign alloc_err  = alloc_fire & ((alloc_wf_count_i == '0) | dup_hit);
    assign alloc_ok   = alloc_fire & ~alloc_err;

    assign wf_fire = wf_done_valid_i & wf_done_ready_o;
    assign wf_miss = wf_fire & ~wf_hit;
    assign wf_last = wf_fire & wf_hit & (rem_q[wf_idx] == WF_CNT_WIDTH'(1));

    // Hit entry is always valid and the free entry never is, so the two writes
    // below cannot collide.
    always_comb begin
        vld_d = vld_q;
        id_d  = id_q;
        rem_d = rem_q;
        if (wf_fire && wf_hit) begin
            if (wf_last) begin
                vld_d[wf_idx] = 1'b0;
            end else begin
                rem_d[wf_idx] = rem_q[wf_idx] - WF_CNT_WIDTH'(1);
            end
        end
        if (alloc_ok) begin
            vld_d[free_idx] = 1'b1;
            id_d[free_idx]  = alloc_wg_id_i;
            rem_d[free_idx] = alloc_wf_count_i;
        end
    end

    always_comb begin
        out_vld_d = out_vld_q;
        out_id_d  = out_id_q;
        if (wf_last) begin
            out_vld_d = 1'b1;
            out_id_d  = wf_done_wg_id_i;
        end else if (wg_done_ready_i) begin
            out_vld_d = 1'b0;
        end
    end

    always_comb begin
        err_d  = alloc_err | wf_miss;
        live_d = live_q;
        case ({alloc_ok, wf_last})
            2'b10:   live_d = live_q + LIVE_W'(1);
            2'b01:   live_d = live_q - LIVE_W'(1);
            default: live_d = live_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            out_vld_q <= 1'b0;
            out_id_q  <= '0;
            err_q     <= 1'b0;
            live_q    <= '0;
        end else begin
            vld_q     <= vld_d;
            out_vld_q <= out_vld_d;
            out_id_q  <= out_id_d;
            err_q     <= err_d;
            live_q    <= live_d;
        end
    end

    // Entry payload is qualified by vld_q and needs no reset.
    always_ff @(posedge clk) begin
        id_q  <= id_d;
        rem_q <= rem_d;
    end

    assign wg_done_valid_o = out_vld_q;
    assign wg_done_wg_id_o = out_id_q;
    assign err_o           = err_q;
    assign live_cnt_o      = live_q;

endmodule

// File: tb/tb_wg_done_tracker.sv
// Bench for wg_done_tracker: directed scenarios plus random traffic, all checked
// every cycle against an associative-array model of the tracking table.
module tb_wg_done_tracker;

    localparam int IDW  = 15;
    localparam int NMAX = 32;
    localparam int CW   = 6;
    localparam int LW   = $clog2(NMAX) + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alloc_valid_i;
    logic            alloc_ready_o;
    logic [IDW-1:0]  alloc_wg_id_i;
    logic [CW-1:0]   alloc_wf_count_i;
    logic            wf_done_valid_i;
    logic            wf_done_ready_o;
    logic [IDW-1:0]  wf_done_wg_id_i;
    logic            wg_done_valid_o;
    logic            wg_done_ready_i;
    logic [IDW-1:0]  wg_done_wg_id_o;
    logic            err_o;
    logic [LW-1:0]   live_cnt_o;

    wg_done_tracker #(.WG_ID_WIDTH(IDW), .WG_NUM_MAX(NMAX), .WF_CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
        .alloc_wg_id_i(alloc_wg_id_i), .alloc_wf_count_i(alloc_wf_count_i),
        .wf_done_valid_i(wf_done_valid_i), .wf_done_ready_o(wf_done_ready_o),
        .wf_done_wg_id_i(wf_done_wg_id_i),
        .wg_done_valid_o(wg_done_valid_o), .wg_done_ready_i(wg_done_ready_i),
        .wg_done_wg_id_o(wg_done_wg_id_o),
        .err_o(err_o), .live_cnt_o(live_cnt_o)
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int mis_cnt = 0;

    // Reference model: live workgroups keyed by ID -> wavefronts still outstanding.
    int tbl [int];
    bit m_vld;
    int m_id;
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        if (obs !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        tbl.delete();
        m_vld = 1'b0;
        m_id  = 0;
        m_err = 1'b0;
    endtask

    task automatic check_outputs();
        chk("alloc_ready", 32'(alloc_ready_o), 32'(tbl.num() < NMAX));
        chk("wf_ready", 32'(wf_done_ready_o), 32'(!m_vld || wg_done_ready_i));
        chk("done_valid", 32'(wg_done_valid_o), 32'(m_vld));
        if (m_vld) chk("done_id", 32'(wg_done_wg_id_o), 32'(m_id));
        chk("err", 32'(err_o), 32'(m_err));
        chk("live_cnt", 32'(live_cnt_o), 32'(tbl.num()));
    endtask

    // Apply one clock of the handshake rules to the model, using the values on
    // the inputs during this cycle and the model state from its start.
    task automatic model_update();
        bit a_fire, w_fire, a_err, w_err, load;
        int aid, wid, acnt;
        aid    = int'(alloc_wg_id_i);
        wid    = int'(wf_done_wg_id_i);
        acnt   = int'(alloc_wf_count_i);
        a_fire = alloc_valid_i && (tbl.num() < NMAX);
        w_fire = wf_done_valid_i && (!m_vld || wg_done_ready_i);
        a_err  = a_fire && (acnt == 0 || tbl.exists(aid));
        w_err  = w_fire && !tbl.exists(wid);
        load   = 1'b0;
        if (w_fire && !w_err) begin
            if (tbl[wid] == 1) begin
                tbl.delete(wid);
                load = 1'b1;
            end else begin
                tbl[wid] = tbl[wid] - 1;
            end
        end
        if (a_fire && !a_err) tbl[aid] = acnt;
        if (load) begin
            m_vld = 1'b1;
            m_id  = wid;
        end else if (wg_done_ready_i) begin
            m_vld = 1'b0;
        end
        m_err = a_err || w_err;
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit av, input int aid, input int acnt,
                         input bit wv, input int wid, input bit rdy);
        alloc_valid_i    = av;
        alloc_wg_id_i    = IDW'(aid);
        alloc_wf_count_i = CW'(acnt);
        wf_done_valid_i  = wv;
        wf_done_wg_id_i  = IDW'(wid);
        wg_done_ready_i  = rdy;
        step();
    endtask

    task automatic idle();
        drive(1'b0, 0, 1, 1'b0, 0, 1'b1);
    endtask

    initial begin
        int keys[$];
        rst_n = 1'b0;
        alloc_valid_i = 1'b0; alloc_wg_id_i = '0; alloc_wf_count_i = '0;
        wf_done_valid_i = 1'b0; wf_done_wg_id_i = '0; wg_done_ready_i = 1'b1;
        model_reset();
        #1;
        chk("rst_done_valid", 32'(wg_done_valid_o), 32'd0);
        chk("rst_done_id", 32'(wg_done_wg_id_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_live", 32'(live_cnt_o), 32'd0);
        chk("rst_alloc_ready", 32'(alloc_ready_o), 32'd1);
        chk("rst_wf_ready", 32'(wf_done_ready_o), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic retire of a three-wavefront workgroup
        drive(1'b1, 5, 3, 1'b0, 0, 1'b1);
        chk("t1_live1", 32'(live_cnt_o), 32'd1);
        repeat (3) drive(1'b0, 0, 1, 1'b1, 5, 1'b1);
        chk("t1_done", 32'(wg_done_valid_o), 32'd1);
        chk("t1_id", 32'(wg_done_wg_id_o), 32'd5);
        chk("t1_live0", 32'(live_cnt_o), 32'd0);
        idle();

        // Backpressure on the completion output
        drive(1'b1, 1, 1, 1'b0, 0, 1'b1);
        drive(1'b1, 2, 1, 1'b0, 0, 1'b1);
        drive(1'b0, 0, 1, 1'b1, 1, 1'b0);
        chk("t2_first", 32'(wg_done_wg_id_o), 32'd1);
        drive(1'b0, 0, 1, 1'b1, 2, 1'b0);
        chk("t2_blocked", 32'(wf_done_ready_o), 32'd0);
        drive(1'b0, 0, 1, 1'b1, 2, 1'b0);
        drive(1'b0, 0, 1, 1'b1, 2, 1'b1);
        chk("t2_second_vld", 32'(wg_done_valid_o), 32'd1);
        chk("t2_second_id", 32'(wg_done_wg_id_o), 32'd2);
        idle();

        // Fill the table, free one slot, refill it
        for (int i = 0; i < NMAX; i++) drive(1'b1, 100 + i, 2, 1'b0, 0, 1'b1);
        chk("t3_full", 32'(alloc_ready_o), 32'd0);
        drive(1'b1, 300, 1, 1'b0, 0, 1'b1);
        chk("t3_full_live", 32'(live_cnt_o), 32'(NMAX));
        drive(1'b0, 0, 1, 1'b1, 100, 1'b1);
        drive(1'b0, 0, 1, 1'b1, 100, 1'b1);
        chk("t3_freed", 32'(alloc_ready_o), 32'd1);
        drive(1'b1, 200, 1, 1'b0, 0, 1'b1);
        chk("t3_refill", 32'(live_cnt_o), 32'(NMAX));
        for (int i = 1; i < NMAX; i++) begin
            drive(1'b0, 0, 1, 1'b1, 100 + i, 1'b1);
            drive(1'b0, 0, 1, 1'b1, 100 + i, 1'b1);
        end
        drive(1'b0, 0, 1, 1'b1, 200, 1'b1);
        idle();

        // Error cases
        drive(1'b0, 0, 1, 1'b1, 99, 1'b1);
        chk("t4_miss_err", 32'(err_o), 32'd1);
        idle();
        chk("t4_err_pulse", 32'(err_o), 32'd0);
        drive(1'b1, 50, 0, 1'b0, 0, 1'b1);
        chk("t4_zero_err", 32'(err_o), 32'd1);
        drive(1'b1, 50, 2, 1'b0, 0, 1'b1);
        drive(1'b1, 50, 1, 1'b0, 0, 1'b1);
        chk("t4_dup_err", 32'(err_o), 32'd1);
        chk("t4_dup_live", 32'(live_cnt_o), 32'd1);
        drive(1'b0, 0, 1, 1'b1, 50, 1'b1);
        drive(1'b0, 0, 1, 1'b1, 50, 1'b1);
        idle();

        // Simultaneous alloc and final wf_done
        drive(1'b1, 3, 1, 1'b0, 0, 1'b1);
        drive(1'b1, 7, 1, 1'b1, 3, 1'b1);
        chk("t5_live", 32'(live_cnt_o), 32'd1);
        chk("t5_id", 32'(wg_done_wg_id_o), 32'd3);
        drive(1'b1, 8, 1, 1'b1, 8, 1'b1);
        chk("t5_same_id_err", 32'(err_o), 32'd1);
        drive(1'b0, 0, 1, 1'b1, 7, 1'b1);
        drive(1'b0, 0, 1, 1'b1, 8, 1'b1);
        idle();

        // Asynchronous reset with a completion pending
        drive(1'b1, 40, 1, 1'b0, 0, 1'b0);
        drive(1'b0, 0, 1, 1'b1, 40, 1'b0);
        chk("t6_pending", 32'(wg_done_valid_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", 32'(wg_done_valid_o), 32'd0);
        chk("t6_rst_live", 32'(live_cnt_o), 32'd0);
        chk("t6_rst_id", 32'(wg_done_wg_id_o), 32'd0);
        model_reset();
        alloc_valid_i = 1'b0; wf_done_valid_i = 1'b0; wg_done_ready_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 0, 1, 1'b1, 40, 1'b1);
        chk("t6_stale_err", 32'(err_o), 32'd1);
        idle();

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            bit av, wv, rdy;
            int aid, acnt, wid;
            av   = ($urandom_range(0, 1) == 1);
            aid  = $urandom_range(0, 47);
            acnt = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 3);
            wv   = ($urandom_range(0, 9) < 6);
            rdy  = ($urandom_range(0, 9) < 7);
            keys.delete();
            foreach (tbl[k]) keys.push_back(k);
            if (keys.size() > 0 && $urandom_range(0, 99) < 85)
                wid = keys[$urandom_range(0, keys.size() - 1)];
            else
                wid = $urandom_range(0, 63);
            drive(av, aid, acnt, wv, wid, rdy);
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
